// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK
  } scan_state_t;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [31:0] SEL_NONE  = {32{1'b1}};

  // Entry [n] is the dp-off pattern for hex digit n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load port and display bus of the scan controller.
// master = frame source / display consumer, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    enable;
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   seg_sel;
  logic [7:0]              seg_led;

  modport master (
    output enable, load_valid, load_data, load_dp,
    input  load_ready, frame_done, seg_sel, seg_led
  );

  modport slave (
    input  enable, load_valid, load_data, load_dp,
    output load_ready, frame_done, seg_sel, seg_led
  );
endinterface

// File: rtl/seg_hex_encoder.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_hex_encoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = hex_to_seg(nibble) & {~dp, 7'h7F};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler with dead-time blanking and a double-buffered load port.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int TW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] DRIVE_LAST = TW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SLOT_LAST  = TW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t           state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [TW-1:0]         tick_reg, tick_next;
  logic [DW-1:0]         active_data_reg, active_data_next;
  logic [NUM_DIGITS-1:0] active_dp_reg, active_dp_next;
  logic [DW-1:0]         shadow_data_reg, shadow_data_next;
  logic [NUM_DIGITS-1:0] shadow_dp_reg, shadow_dp_next;
  logic                  pending_reg, pending_next;
  logic [NUM_DIGITS-1:0] seg_sel_reg, seg_sel_next;
  logic [7:0]            seg_led_reg, seg_led_next;
  logic                  frame_done_reg, frame_done_next;

  logic                  frame_edge;
  logic [3:0]            enc_nibble;
  logic                  enc_dp;
  logic [7:0]            enc_seg;
  logic [NUM_DIGITS-1:0] lz_blank;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tick_next  = tick_reg;
    if (!bus.enable) begin
      state_next = IDLE;
      idx_next   = '0;
      tick_next  = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = DRIVE;
          idx_next   = '0;
          tick_next  = '0;
        end
        DRIVE: begin
          tick_next = tick_reg + 1'b1;
          if (tick_reg == DRIVE_LAST) state_next = BLANK;
        end
        BLANK: begin
          if (tick_reg == SLOT_LAST) begin
            state_next = DRIVE;
            tick_next  = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pending data lands on the frame edge, or straight away while idle.
  assign frame_edge = (state_reg == BLANK) && (tick_reg == SLOT_LAST) && (idx_reg == IDX_LAST);

  always_comb begin
    active_data_next = active_data_reg;
    active_dp_next   = active_dp_reg;
    shadow_data_next = shadow_data_reg;
    shadow_dp_next   = shadow_dp_reg;
    pending_next     = pending_reg;
    if (pending_reg && ((state_reg == IDLE) || frame_edge)) begin
      active_data_next = shadow_data_reg;
      active_dp_next   = shadow_dp_reg;
      pending_next     = 1'b0;
    end
    if (bus.load_valid && !pending_reg) begin
      shadow_data_next = bus.load_data;
      shadow_dp_next   = bus.load_dp;
      pending_next     = 1'b1;
    end
  end

  assign enc_nibble = active_data_next[4*idx_next +: 4];
  assign enc_dp     = active_dp_next[idx_next];

  seg_hex_encoder u_encoder (
    .nibble (enc_nibble),
    .dp     (enc_dp),
    .seg    (enc_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz_blank[gi] = (active_data_next[DW-1:4*gi] == '0);
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs are derived from next-state values so the registers line up with the state.
  always_comb begin
    seg_sel_next    = SEL_NONE[NUM_DIGITS-1:0];
    seg_led_next    = SEG_BLANK;
    frame_done_next = (state_next == BLANK) && (tick_next == SLOT_LAST) && (idx_next == IDX_LAST);
    if (state_next == DRIVE) begin
      seg_sel_next[idx_next] = 1'b0;
      seg_led_next = lz_blank[idx_next] ? (SEG_BLANK & {~enc_dp, 7'h7F}) : enc_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      tick_reg        <= '0;
      active_data_reg <= '0;
      active_dp_reg   <= '0;
      shadow_data_reg <= '0;
      shadow_dp_reg   <= '0;
      pending_reg     <= 1'b0;
      seg_sel_reg     <= SEL_NONE[NUM_DIGITS-1:0];
      seg_led_reg     <= SEG_BLANK;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      tick_reg        <= tick_next;
      active_data_reg <= active_data_next;
      active_dp_reg   <= active_dp_next;
      shadow_data_reg <= shadow_data_next;
      shadow_dp_reg   <= shadow_dp_next;
      pending_reg     <= pending_next;
      seg_sel_reg     <= seg_sel_next;
      seg_led_reg     <= seg_led_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  assign bus.seg_sel    = seg_sel_reg;
  assign bus.seg_led    = seg_led_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.load_ready = ~pending_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed steps plus randomized traffic,
// compared every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int N     = 6;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * DC;

  localparam logic [7:0] HEX_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: running flag plus position within the frame (digit = pos/DC, phase = pos%DC).
  bit          m_run;
  int          m_pos;
  logic [23:0] m_act, m_sh;
  logic [5:0]  m_actdp, m_shdp;
  bit          m_pend;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_pend = 0;
    m_act = '0; m_sh = '0; m_actdp = '0; m_shdp = '0;
  endtask

  function automatic bit in_drive();
    return m_run && ((m_pos % DC) < (DC - BC));
  endfunction

  function automatic logic [5:0] exp_sel();
    logic [5:0] s;
    s = 6'h3F;
    if (in_drive()) s[m_pos / DC] = 1'b0;
    return s;
  endfunction

  function automatic logic [7:0] exp_led();
    int d;
    int hi;
    logic [7:0] v;
    if (!in_drive()) return 8'hFF;
    d = m_pos / DC;
    v = HEX_TBL[m_act[d*4 +: 4]];
    hi = -1;
    for (int i = 0; i < N; i++) if (m_act[i*4 +: 4] != 4'h0) hi = i;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && d > hi) v = 8'hFF;
`endif
    if (m_actdp[d]) v[7] = 1'b0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("seg_sel",    32'(bus.seg_sel),    32'(exp_sel()));
    check("seg_led",    32'(bus.seg_led),    32'(exp_led()));
    check("frame_done", 32'(bus.frame_done), 32'(m_run && m_pos == FRAME - 1));
    check("load_ready", 32'(bus.load_ready), 32'(!m_pend));
  endtask

  // One clock: drive inputs at the negedge, predict, check at the next negedge.
  task automatic step(input bit en, input bit lv, input logic [23:0] d, input logic [5:0] dp);
    bit fedge;
    bit acc;
    bus.enable = en; bus.load_valid = lv; bus.load_data = d; bus.load_dp = dp;
    fedge = m_run && (m_pos == FRAME - 1);
    acc   = lv && !m_pend;
    if (m_pend && (!m_run || fedge)) begin
      m_act = m_sh; m_actdp = m_shdp; m_pend = 0;
    end
    if (acc) begin
      m_sh = d; m_shdp = dp; m_pend = 1;
      $display("load accepted data=%h dp=%b t=%0t", d, dp, $time);
    end
    if (!en) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, 6'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_dp = '0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;

    // 012345 loaded while idle, then scanned
    step(1'b0, 1'b1, 24'h012345, 6'h00);
    idle_steps(60);

    // mid-frame load waits for the frame edge
    step(1'b1, 1'b1, 24'hAAAAAA, 6'h00);
    idle_steps(50);

    // back-to-back loads: second held until the first is consumed
    step(1'b1, 1'b1, 24'h111111, 6'h2A);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 24'h222222, 6'h15);
    idle_steps(30);

    // enable drop during digit 3
    while (!(m_run && (m_pos / DC) == 3 && (m_pos % DC) == 2)) step(1'b1, 1'b0, 24'h0, 6'h0);
    step(1'b0, 1'b0, 24'h0, 6'h0);
    step(1'b0, 1'b0, 24'h0, 6'h0);
    idle_steps(12);

    // decimal point and leading-zero patterns
    step(1'b1, 1'b1, 24'h000005, 6'b000001);
    idle_steps(100);
    step(1'b1, 1'b1, 24'h000070, 6'b000000);
    idle_steps(100);

    // async reset mid-DRIVE with a load pending
    step(1'b1, 1'b1, 24'h987654, 6'h3F);
    while (!(m_run && (m_pos % DC) == 2)) step(1'b1, 1'b0, 24'h0, 6'h0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    idle_steps(60);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [23:0] rd;
      logic [5:0]  rdp;
      bit          ren;
      bit          rlv;
      rd  = 24'($urandom);
      rdp = 6'($urandom);
      ren = ($urandom_range(0, 99) != 0);
      rlv = ($urandom_range(0, 7) == 0);
      step(ren, rlv, rd, rdp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
